piso_tx: RTL and testbench

Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, LSB first. It is the transmit end that drives the team's 4-bit serial-in shift registers: a right-shifting receiver that clocks in WIDTH bits ends up holding the word in its original bit order. A clock-enable input paces the shift rate, so a divided tick can drive a slower serial link.

---
 rtl/piso_tx.sv | 93 +++++++++
 tb/tb_piso_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out shift transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// LSB first, one bit per cycle with ce=1. A right-shifting receiver that
// samples so on (so_valid & ce) ends up holding the word in original order.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset
//   din        parallel word to transmit
//   din_valid  din holds a word to send
//   din_ready  transmitter can accept a word this cycle (state-derived)
//   ce         shift enable, one bit consumed per cycle with ce=1
//   so         serial data out (0 while idle)
//   so_valid   so holds a frame bit (state-derived)
//   done       one-cycle pulse in the first idle cycle after the last bit
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             ce,
    output logic             so,
    output logic             so_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done_nxt;

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ce) begin
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        shreg_nxt = shreg >> 1;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on din_valid or ce.
    assign din_ready = (state == IDLE);
    assign so_valid  = (state == SHIFT);
    assign so        = (state == SHIFT) & shreg[0];

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] din;
    logic       din_valid, ce;
    logic       din_ready, so, so_valid, done;

    logic [7:0] din8;
    logic       din_valid8, ce8;
    logic       din_ready8, so8, so_valid8, done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4)) u4 (
        .clk(clk), .clear(clear), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ce(ce), .so(so), .so_valid(so_valid), .done(done)
    );

    piso_tx #(.WIDTH(8)) u8 (
        .clk(clk), .clear(clear), .din(din8), .din_valid(din_valid8),
        .din_ready(din_ready8), .ce(ce8), .so(so8), .so_valid(so_valid8), .done(done8)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; din = 4'b1111; din_valid = 1'b1; ce = 1'b1;
        din8 = 8'hFF; din_valid8 = 1'b1; ce8 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if ({din_ready, so_valid, so, done} !== 4'b1000) begin
                bad++; $display("FAIL reset4[%0d]: got rdy/vld/so/done=%b want=1000", c, {din_ready, so_valid, so, done});
            end
            total++; if ({din_ready8, so_valid8, so8, done8} !== 4'b1000) begin
                bad++; $display("FAIL reset8[%0d]: got rdy/vld/so/done=%b want=1000", c, {din_ready8, so_valid8, so8, done8});
            end
        end
        clear = 1'b0; din_valid = 1'b0; din_valid8 = 1'b0;
        tick();
        total++; if ({din_ready, so_valid, done} !== 3'b100) begin
            bad++; $display("FAIL reset_idle: got rdy/vld/done=%b want=100", {din_ready, so_valid, done});
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp = 4'b1011;   // bit k expected on so in k-th cycle after accept
        logic [3:0] rx  = 4'b0000;
        din = 4'b1011; din_valid = 1'b1; ce = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (so !== exp[k] || so_valid !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL basic_bit[%0d]: got so=%b vld=%b done=%b want so=%b vld=1 done=0", k, so, so_valid, done, exp[k]);
            end
            if (so_valid & ce) rx = {so, rx[3:1]};
            tick();
        end
        total++; if (done !== 1'b1 || din_ready !== 1'b1 || so_valid !== 1'b0 || so !== 1'b0) begin
            bad++; $display("FAIL basic_done: got done=%b rdy=%b vld=%b so=%b want 1 1 0 0", done, din_ready, so_valid, so);
        end
        total++; if (rx !== 4'b1011) begin
            bad++; $display("FAIL basic_rx: got=%b want=1011", rx);
        end
        tick();
        total++; if (done !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse: got done=%b want=0", done);
        end
    endtask

    task automatic test_paced();
        logic [3:0] exp = 4'b0110;
        int         ndone = 0;
        din = 4'b0110; din_valid = 1'b1; ce = 1'b0;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                ce = (j == 2);
                total++; if (so !== exp[k] || so_valid !== 1'b1) begin
                    bad++; $display("FAIL paced_bit[%0d.%0d]: got so=%b vld=%b want so=%b vld=1", k, j, so, so_valid, exp[k]);
                end
                if (done) ndone++;
                tick();
            end
        end
        ce = 1'b0;
        if (done) ndone++;
        total++; if (done !== 1'b1 || din_ready !== 1'b1) begin
            bad++; $display("FAIL paced_done: got done=%b rdy=%b want 1 1", done, din_ready);
        end
        tick();
        if (done) ndone++;
        total++; if (ndone !== 1) begin
            bad++; $display("FAIL paced_done_count: got=%0d want=1", ndone);
        end
        ce = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp1 = 4'b0001;
        din = 4'b0001; din_valid = 1'b1; ce = 1'b1;
        tick();
        din = 4'b1111;   // held valid during SHIFT, must be ignored
        for (int k = 0; k < 4; k++) begin
            total++; if (so !== exp1[k] || din_ready !== 1'b0) begin
                bad++; $display("FAIL busy_bit[%0d]: got so=%b rdy=%b want so=%b rdy=0", k, so, din_ready, exp1[k]);
            end
            tick();
        end
        total++; if (done !== 1'b1 || din_ready !== 1'b1) begin
            bad++; $display("FAIL busy_done: got done=%b rdy=%b want 1 1", done, din_ready);
        end
        tick();          // 4'b1111 accepted at the end of the done cycle
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (so !== 1'b1 || so_valid !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL busy_second_bit[%0d]: got so=%b vld=%b done=%b want 1 1 0", k, so, so_valid, done);
            end
            tick();
        end
        total++; if (done !== 1'b1) begin
            bad++; $display("FAIL busy_second_done: got done=%b want=1", done);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [3:0] exp2 = 4'b0101;
        din = 4'b1010; din_valid = 1'b1; ce = 1'b1;
        tick();
        din_valid = 1'b0;
        total++; if (so !== 1'b0) begin bad++; $display("FAIL abort_bit0: got so=%b want=0", so); end
        tick();
        total++; if (so !== 1'b1) begin bad++; $display("FAIL abort_bit1: got so=%b want=1", so); end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if ({din_ready, so_valid, so, done} !== 4'b1000) begin
            bad++; $display("FAIL abort_idle: got rdy/vld/so/done=%b want=1000", {din_ready, so_valid, so, done});
        end
        tick();
        total++; if (done !== 1'b0 || so_valid !== 1'b0) begin
            bad++; $display("FAIL abort_nodone: got done=%b vld=%b want 0 0", done, so_valid);
        end
        din = 4'b0101; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (so !== exp2[k] || so_valid !== 1'b1) begin
                bad++; $display("FAIL abort_new_bit[%0d]: got so=%b vld=%b want so=%b vld=1", k, so, so_valid, exp2[k]);
            end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_new_done: got done=%b want=1", done); end
        tick();
    endtask

    task automatic test_clear_last();
        din = 4'b1001; din_valid = 1'b1; ce = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (so !== 1'b1 || so_valid !== 1'b1) begin
            bad++; $display("FAIL clrlast_bit3: got so=%b vld=%b want 1 1", so, so_valid);
        end
        clear = 1'b1;    // same edge as the final ce
        tick();
        clear = 1'b0;
        total++; if (done !== 1'b0 || din_ready !== 1'b1) begin
            bad++; $display("FAIL clrlast_done: got done=%b rdy=%b want 0 1", done, din_ready);
        end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL clrlast_after: got done=%b want=0", done); end
    endtask

    task automatic test_width8();
        logic [7:0] exp8 = 8'b1010_0101;   // so sequence 1,0,1,0,0,1,0,1 = bits 0..7 of A5
        din8 = 8'hA5; din_valid8 = 1'b1; ce8 = 1'b1;
        tick();
        din_valid8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++; if (so8 !== exp8[k] || so_valid8 !== 1'b1 || done8 !== 1'b0) begin
                bad++; $display("FAIL w8_bit[%0d]: got so=%b vld=%b done=%b want so=%b vld=1 done=0", k, so8, so_valid8, done8, exp8[k]);
            end
            tick();
        end
        total++; if (done8 !== 1'b1 || din_ready8 !== 1'b1 || so_valid8 !== 1'b0) begin
            bad++; $display("FAIL w8_done: got done=%b rdy=%b vld=%b want 1 1 0", done8, din_ready8, so_valid8);
        end
        tick();
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL w8_done_pulse: got done=%b want=0", done8); end
    endtask

    initial begin
        clear = 1'b0; din = '0; din_valid = 1'b0; ce = 1'b0;
        din8 = '0; din_valid8 = 1'b0; ce8 = 1'b0;
        test_reset();
        test_basic();
        test_paced();
        test_back_to_back();
        test_abort();
        test_clear_last();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
